// File: rtl/branch_resolve_bht.sv
// Branch resolution unit: 2-bit saturating BHT predictor, training on resolved
// outcomes, mispredict detection with a registered redirect/flush to fetch,
// and saturating branch / mispredict performance counters.
module branch_resolve_bht #(
    parameter int ADDR_SIZE   = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int IDX_BITS    = $clog2(BHT_ENTRIES),
    parameter int CNT_SIZE    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [ADDR_SIZE-1:0] i_fetch_pc,
    output logic                 o_pred_taken,
    input  logic                 i_br_valid,
    input  logic                 i_stall,
    input  logic [ADDR_SIZE-1:0] i_br_pc,
    input  logic [ADDR_SIZE-1:0] i_br_target,
    input  logic                 i_br_taken,
    input  logic                 i_br_pred_taken,
    output logic                 o_redirect_valid,
    output logic [ADDR_SIZE-1:0] o_redirect_pc,
    input  logic                 i_redirect_ready,
    output logic                 o_flush,
    output logic [CNT_SIZE-1:0]  o_branch_count,
    output logic [CNT_SIZE-1:0]  o_mispredict_count
);

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [1:0]             bht [BHT_ENTRIES];
    logic [IDX_BITS-1:0]    fetch_idx;
    logic [IDX_BITS-1:0]    br_idx;
    logic                   resolve;
    logic                   mispredict;
    logic                   take_redirect;
    logic [ADDR_SIZE-1:0]   corrected_pc;
    logic                   unused_fetch_bits;

    assign fetch_idx         = i_fetch_pc[IDX_BITS+1:2];
    assign br_idx            = i_br_pc[IDX_BITS+1:2];
    assign resolve           = i_br_valid && !i_stall;
    assign mispredict        = i_br_taken != i_br_pred_taken;
    assign take_redirect     = resolve && mispredict && (state == IDLE);
    assign corrected_pc      = i_br_taken ? i_br_target : i_br_pc + ADDR_SIZE'(4);
    assign unused_fetch_bits = ^{i_fetch_pc[ADDR_SIZE-1:IDX_BITS+2], i_fetch_pc[1:0]};

    // Prediction is the counter MSB; a same-cycle update is not yet visible here.
    assign o_pred_taken = bht[fetch_idx][1];

    // Train the indexed counter on every resolve event, saturating at both ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (resolve) begin
            if (i_br_taken && bht[br_idx] != 2'b11) begin
                bht[br_idx] <= bht[br_idx] + 2'b01;
            end else if (!i_br_taken && bht[br_idx] != 2'b00) begin
                bht[br_idx] <= bht[br_idx] - 2'b01;
            end
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_branch_count     <= '0;
            o_mispredict_count <= '0;
        end else if (resolve) begin
            if (o_branch_count != '1) begin
                o_branch_count <= o_branch_count + CNT_SIZE'(1);
            end
            if (mispredict && o_mispredict_count != '1) begin
                o_mispredict_count <= o_mispredict_count + CNT_SIZE'(1);
            end
        end
    end

    // Capture the corrected PC only when a new redirect starts; held while pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_redirect_pc <= '0;
        end else if (take_redirect) begin
            o_redirect_pc <= corrected_pc;
        end
    end

    // Redirect FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a pending redirect wins over later wrong-path mispredicts.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (take_redirect)    state_next = REDIRECT;
            REDIRECT: if (i_redirect_ready) state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // Flush accompanies the redirect request for its whole lifetime.
    always_comb begin
        o_redirect_valid = (state == REDIRECT);
        o_flush          = (state == REDIRECT);
    end

endmodule
